// File: rtl/match_clear.sv
// match_clear: snapshots an 8x8 board of 3-bit cells, scans rows and then
// columns for runs of three or more equal nonzero pieces, zeroes the matched
// cells and, when anything was cleared, holds a handshake with the refresh
// stage until it acknowledges.
// Optional feature: define MATCH_SCORE_EN to build a saturating 16-bit score
// accumulator. Without it, score is tied to zero.
module match_clear (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [191:0] board,
  input  logic         refreshed,
  output logic         busy,
  output logic [191:0] cleared_board,
  output logic [63:0]  clear_mask,
  output logic [6:0]   clear_count,
  output logic         found,
  output logic         ok_to_refresh,
  output logic [15:0]  score,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN_H = 3'd1,
    S_SCAN_V = 3'd2,
    S_APPLY  = 3'd3,
    S_REQ    = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  state_t         state_q;
  logic [191:0]   snap_q;
  logic [63:0]    mask_q;
  logic [63:0]    mask_d;
  logic [63:0]    hit_s;
  logic [2:0]     idx_q;
  logic           busy_q;
  logic [191:0]   cleared_q;
  logic [63:0]    clr_mask_q;
  logic [6:0]     clr_count_q;
  logic           found_q;
  logic           ok_q;
  logic           done_q;

  // Cell (r,c) of a flattened board.
  function automatic logic [2:0] cell_at(input logic [191:0] b, input int r, input int c);
    return b[(8*r+c)*3 +: 3];
  endfunction

  // Three equal, nonzero pieces in a window.
  function automatic logic is_run(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    return (a != 3'd0) && (a == b) && (b == c);
  endfunction

  // Number of set bits in a 64-bit mask.
  function automatic logic [6:0] popcount64(input logic [63:0] m);
    logic [6:0] n;
    n = 7'd0;
    for (int i = 0; i < 64; i++) begin
      n = n + {6'd0, m[i]};
    end
    return n;
  endfunction

  // Board with every masked cell forced to empty.
  function automatic logic [191:0] clear_cells(input logic [191:0] b, input logic [63:0] m);
    logic [191:0] o;
    o = b;
    for (int i = 0; i < 64; i++) begin
      if (m[i]) begin
        o[i*3 +: 3] = 3'd0;
      end else begin
        o[i*3 +: 3] = b[i*3 +: 3];
      end
    end
    return o;
  endfunction

  // Window test along the row or column currently selected by the index.
  always_comb begin
    hit_s = 64'd0;
    if (state_q == S_SCAN_H) begin
      for (int c = 0; c < 6; c++) begin
        if (is_run(cell_at(snap_q, int'(idx_q), c),
                   cell_at(snap_q, int'(idx_q), c + 1),
                   cell_at(snap_q, int'(idx_q), c + 2))) begin
          hit_s[8*int'(idx_q) + c]     = 1'b1;
          hit_s[8*int'(idx_q) + c + 1] = 1'b1;
          hit_s[8*int'(idx_q) + c + 2] = 1'b1;
        end
      end
    end else if (state_q == S_SCAN_V) begin
      for (int r = 0; r < 6; r++) begin
        if (is_run(cell_at(snap_q, r,     int'(idx_q)),
                   cell_at(snap_q, r + 1, int'(idx_q)),
                   cell_at(snap_q, r + 2, int'(idx_q)))) begin
          hit_s[8*r + int'(idx_q)]       = 1'b1;
          hit_s[8*(r + 1) + int'(idx_q)] = 1'b1;
          hit_s[8*(r + 2) + int'(idx_q)] = 1'b1;
        end
      end
    end else begin
      hit_s = 64'd0;
    end
  end

  assign mask_d = mask_q | hit_s;

  // Control FSM with registered outputs; done defaults low so it only pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      snap_q      <= 192'd0;
      mask_q      <= 64'd0;
      idx_q       <= 3'd0;
      busy_q      <= 1'b0;
      cleared_q   <= 192'd0;
      clr_mask_q  <= 64'd0;
      clr_count_q <= 7'd0;
      found_q     <= 1'b0;
      ok_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          busy_q <= start;
          if (start) begin
            snap_q  <= board;
            mask_q  <= 64'd0;
            idx_q   <= 3'd0;
            state_q <= S_SCAN_H;
          end
        end
        S_SCAN_H: begin
          busy_q <= 1'b1;
          mask_q <= mask_d;
          if (idx_q == 3'd7) begin
            idx_q   <= 3'd0;
            state_q <= S_SCAN_V;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        S_SCAN_V: begin
          busy_q <= 1'b1;
          mask_q <= mask_d;
          if (idx_q == 3'd7) begin
            idx_q   <= 3'd0;
            state_q <= S_APPLY;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        S_APPLY: begin
          busy_q      <= 1'b1;
          cleared_q   <= clear_cells(snap_q, mask_q);
          clr_mask_q  <= mask_q;
          clr_count_q <= popcount64(mask_q);
          found_q     <= |mask_q;
          state_q     <= (|mask_q) ? S_REQ : S_FIN;
        end
        S_REQ: begin
          busy_q <= 1'b1;
          // The first REQ cycle raises the request; the acknowledge is
          // only looked at once the request is visible to the refresh stage.
          if (!ok_q) begin
            ok_q <= 1'b1;
          end else if (refreshed) begin
            ok_q    <= 1'b0;
            state_q <= S_FIN;
          end
        end
        S_FIN: begin
          busy_q  <= 1'b1;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          ok_q    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef MATCH_SCORE_EN
  logic [15:0] score_q;
  logic [16:0] score_sum_s;

  assign score_sum_s = {1'b0, score_q} + {10'd0, popcount64(mask_q)};

  // Saturating accumulation of cleared cells, updated once per APPLY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q <= 16'd0;
    end else if (state_q == S_APPLY) begin
      score_q <= score_sum_s[16] ? 16'hFFFF : score_sum_s[15:0];
    end
  end

  assign score = score_q;
`else
  assign score = 16'd0;
`endif

  assign busy          = busy_q;
  assign cleared_board = cleared_q;
  assign clear_mask    = clr_mask_q;
  assign clear_count   = clr_count_q;
  assign found         = found_q;
  assign ok_to_refresh = ok_q;
  assign done          = done_q;

endmodule

// File: tb/tb_match_clear.sv
// Directed, table-driven bench for match_clear.
module tb_match_clear;

  logic         clk;
  logic         reset;
  logic         start;
  logic [191:0] board;
  logic         refreshed;
  logic         busy;
  logic [191:0] cleared_board;
  logic [63:0]  clear_mask;
  logic [6:0]   clear_count;
  logic         found;
  logic         ok_to_refresh;
  logic [15:0]  score;
  logic         done;

  int compared;
  int mismatched;
  int exp_score;

  typedef struct {
    string        name;
    logic [191:0] brd;
    logic [63:0]  mask;
    logic [6:0]   cnt;
    int           delay;
    bit           extra_start;
  } vec_t;

  vec_t vecs[7];

  match_clear dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .board        (board),
    .refreshed    (refreshed),
    .busy         (busy),
    .cleared_board(cleared_board),
    .clear_mask   (clear_mask),
    .clear_count  (clear_count),
    .found        (found),
    .ok_to_refresh(ok_to_refresh),
    .score        (score),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [191:0] put(input logic [191:0] b, input int r, input int c, input logic [2:0] v);
    b[(8*r+c)*3 +: 3] = v;
    return b;
  endfunction

  // Checkerboard of 1/2: no runs anywhere.
  function automatic logic [191:0] bg();
    logic [191:0] b;
    b = 192'd0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b = put(b, r, c, (((r + c) % 2) == 1) ? 3'd2 : 3'd1);
    return b;
  endfunction

  function automatic logic [191:0] apply_mask(input logic [191:0] b, input logic [63:0] m);
    for (int i = 0; i < 64; i++)
      if (m[i]) b[i*3 +: 3] = 3'd0;
    return b;
  endfunction

  task automatic check_score(input string nm);
`ifdef MATCH_SCORE_EN
    chk(nm, {176'd0, score}, {176'd0, exp_score[15:0]});
`else
    chk(nm, {176'd0, score}, 192'd0);
`endif
  endtask

  task automatic run_op(input vec_t v);
    logic [191:0] garbage;
    garbage = (v.cnt == 7'd64) ? 192'd0 : {64{3'd3}};
    @(negedge clk);
    board = v.brd;
    start = 1'b1;
    @(posedge clk);                       // edge 0
    @(negedge clk);
    start = 1'b0;
    board = garbage;                      // must not affect this operation
    chk({v.name, "_busy_start"}, {191'd0, busy}, 192'd1);
    repeat (17) @(posedge clk);           // edges 1..17
    @(negedge clk);
    chk({v.name, "_mask"},    {128'd0, clear_mask}, {128'd0, v.mask});
    chk({v.name, "_count"},   {185'd0, clear_count}, {185'd0, v.cnt});
    chk({v.name, "_found"},   {191'd0, found}, {191'd0, (v.cnt != 7'd0)});
    chk({v.name, "_cleared"}, cleared_board, apply_mask(v.brd, v.mask));
    chk({v.name, "_ok_apply"}, {190'd0, ok_to_refresh, done}, 192'd0);
    if (v.cnt != 7'd0) exp_score = (exp_score + v.cnt > 65535) ? 65535 : exp_score + v.cnt;
    @(posedge clk);                       // edge 18
    @(negedge clk);
    if (v.cnt == 7'd0) begin
      chk({v.name, "_done18"}, {190'd0, ok_to_refresh, done}, 192'd1);
      @(posedge clk);                     // edge 19
      @(negedge clk);
      chk({v.name, "_end"}, {190'd0, busy, done}, 192'd0);
    end else begin
      chk({v.name, "_ok18"}, {190'd0, ok_to_refresh, done}, 192'd2);
      for (int d = 0; d < v.delay; d++) begin
        if (v.extra_start && d == 2) begin
          start = 1'b1;
          board = v.brd;
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({v.name, "_ok_hold"}, {190'd0, ok_to_refresh, done}, 192'd2);
      end
      refreshed = 1'b1;
      @(posedge clk);                     // edge N
      @(negedge clk);
      refreshed = 1'b0;
      chk({v.name, "_ok_drop"}, {190'd0, ok_to_refresh, done}, 192'd0);
      @(posedge clk);                     // edge N+1
      @(negedge clk);
      chk({v.name, "_done"}, {190'd0, ok_to_refresh, done}, 192'd1);
      @(posedge clk);                     // edge N+2
      @(negedge clk);
      chk({v.name, "_end"}, {190'd0, busy, done}, 192'd0);
    end
    check_score({v.name, "_score"});
    // A stray start during REQ or a late refreshed must not restart anything.
    refreshed = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    refreshed = 1'b0;
    chk({v.name, "_quiet"}, {189'd0, busy, ok_to_refresh, done}, 192'd0);
    chk({v.name, "_hold_mask"}, {128'd0, clear_mask}, {128'd0, v.mask});
  endtask

  initial begin
    logic [191:0] b;
    bit saw_bad;
    compared   = 0;
    mismatched = 0;
    exp_score  = 0;
    reset      = 1'b1;
    start      = 1'b0;
    board      = 192'd0;
    refreshed  = 1'b0;

    // Vector table.
    vecs[0] = '{"zero", 192'd0, 64'd0, 7'd0, 0, 1'b0};
    b = bg();
    for (int c = 1; c <= 5; c++) b = put(b, 2, c, 3'd4);
    vecs[1] = '{"row2", b, 64'h0000_0000_003E_0000, 7'd5, 0, 1'b0};
    b = bg();
    for (int c = 2; c <= 4; c++) b = put(b, 3, c, 3'd5);
    for (int r = 1; r <= 5; r++) b = put(b, r, 3, 3'd5);
    vecs[2] = '{"cross", b, 64'h0000_0808_1C08_0800, 7'd7, 3, 1'b0};
    b = bg();
    for (int c = 0; c < 8; c++) b = put(b, 0, c, 3'd7);
    vecs[3] = '{"delay", b, 64'h0000_0000_0000_00FF, 7'd8, 10, 1'b1};
    vecs[4] = '{"full", {64{3'd3}}, 64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 1, 1'b0};
    b = bg();
    for (int r = 5; r < 8; r++) b = put(b, r, 7, 3'd6);
    vecs[5] = '{"col7", b, 64'h8080_8000_0000_0000, 7'd3, 2, 1'b0};
    b = bg();
    b = put(b, 4, 0, 3'd3);
    b = put(b, 4, 1, 3'd3);
    vecs[6] = '{"pair", b, 64'd0, 7'd0, 0, 1'b0};

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {189'd0, busy, ok_to_refresh, done}, 192'd0);
    chk("rst_data", {clear_mask, clear_count, found, cleared_board[119:0]}, 192'd0);
    chk("rst_board", cleared_board, 192'd0);
    chk("rst_score", {176'd0, score}, 192'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_op(vecs[i]);

    // Reset during the column scan of a matching board.
    @(negedge clk);
    board = vecs[1].brd;
    start = 1'b1;
    @(posedge clk);                       // edge 0
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(posedge clk);           // edge 12
    #1 reset = 1'b1;
    #1;
    chk("abort_ctrl", {189'd0, busy, ok_to_refresh, done}, 192'd0);
    chk("abort_data", {clear_mask, clear_count, found, 120'd0}, 192'd0);
    chk("abort_board", cleared_board, 192'd0);
    chk("abort_score", {176'd0, score}, 192'd0);
    exp_score = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    saw_bad = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done || ok_to_refresh || busy) saw_bad = 1'b1;
    end
    chk("abort_no_done", {191'd0, saw_bad}, 192'd0);

    // Fresh operations after the abort; two 5-cell clears accumulate.
    run_op(vecs[1]);
    run_op(vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/match_clear.md
# match_clear

Match detector and initiator for the board refresh handshake. On `start` it snapshots the 8x8 board, scans all rows and then all columns for runs of three or more identical pieces, and zeroes every matched cell. If anything was cleared, it hands the cleared board to the refresh stage with `ok_to_refresh` and holds it until `refreshed` returns. It sits between the swap/input logic and the refresh (gravity/compaction) stage.

## Interface
- No parameters. Board geometry is fixed at 8x8 cells of 3 bits each.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs.
- `start` in 1: request a scan; accepted only in IDLE.
- `board` in 192: current board. Cell (r,c) is `board[(8*r+c)*3 +: 3]`; value 0 means empty, 1..7 are piece kinds.
- `refreshed` in 1: acknowledge from the refresh stage.
- `busy` out 1: high in every state except IDLE.
- `cleared_board` out 192: snapshot with matched cells forced to 0.
- `clear_mask` out 64: bit 8*r+c is set when cell (r,c) was matched.
- `clear_count` out 7: popcount of `clear_mask`, range 0..64.
- `found` out 1: `clear_count` is nonzero; valid from APPLY until the next start.
- `ok_to_refresh` out 1: request to the refresh stage.
- `score` out 16: accumulated cleared cells; see Configuration.
- `done` out 1: one-cycle pulse marking the end of an operation.

## Operation
- States: IDLE, SCAN_H, SCAN_V, APPLY, REQ, FIN.
- IDLE, `start`=1:
  - Latch `board` into the snapshot.
  - Clear the mask and the 3-bit index; go to SCAN_H.
- IDLE, `start`=0: stay in IDLE.
- SCAN_H, index i:
  - Evaluate row i of the snapshot.
  - For every c in 0..5 where cells (i,c), (i,c+1), (i,c+2) are equal and nonzero, OR all three bits into the mask.
  - Runs longer than 3 fall out of the overlapping windows, so a run of 5 marks 5 cells.
  - After i=7, reset the index and go to SCAN_V.
- SCAN_V, index j: same window test along column j over r in 0..5. After j=7, go to APPLY.
- Cells matched both horizontally and vertically are counted once, because the mask is an OR.
- APPLY:
  - Register `cleared_board` (snapshot with masked cells = 0), `clear_mask`, `clear_count` and `found`.
  - If the mask is nonzero, go to REQ; otherwise go to FIN.
- REQ: hold `ok_to_refresh`=1. When `refreshed`=1 is sampled, drop `ok_to_refresh` and go to FIN.
- FIN: pulse `done`=1 for one cycle and return to IDLE.
- `start` outside IDLE is ignored.
- `refreshed` outside REQ is ignored.
- Changes on `board` after the capture edge have no effect on the operation in progress.
- `cleared_board`, `clear_mask`, `clear_count` and `found` hold their values until the next APPLY.

## Timing
- Reset values: `busy`=0, `cleared_board`=0, `clear_mask`=0, `clear_count`=0, `found`=0, `ok_to_refresh`=0, `done`=0, `score`=0. State is IDLE.
- Reset asserted mid-operation aborts immediately: `ok_to_refresh` drops and no `done` is produced.
- Cycle numbering, with `start` sampled at edge 0:
  - Edges 1..8 scan rows 0..7.
  - Edges 9..16 scan columns 0..7.
  - Edge 17 is APPLY; the result outputs are valid after it.
  - Edge 18: `ok_to_refresh` rises (match case) or `done` rises (no-match case).
- No-match latency: `done` is high for the cycle after edge 18; `busy` falls at edge 19.
- Match case, `refreshed` first sampled high at edge N ≥ 19: `ok_to_refresh` falls at N, `done` is high N+1..N+2, and the block is in IDLE from N+2.
- `refreshed` already high at edge 19 is accepted with no wait.

## Configuration
- `MATCH_SCORE_EN` defined:
  - At APPLY, `score` <= `score` + `clear_count`, saturating at 16'hFFFF.
  - `score` is cleared only by `reset`.
- `MATCH_SCORE_EN` undefined: `score` is tied to 0 and no accumulator register is built. All other behaviour is unchanged.

## Test plan
- All-zero board, `start` pulse:
  - `done` after edge 18, `found`=0, `clear_count`=0.
  - `ok_to_refresh` never rises.
  - `cleared_board`=0.
- Row 2 holds cells c=1..5 = 3'd4, all other cells alternate 1/2 with no runs:
  - `clear_mask`=64'h0000_0000_003E_0000, `clear_count`=5.
  - `ok_to_refresh` at edge 18 and held until `refreshed`.
- Cross pattern: row 3 c=2..4 = 5 and column 3 r=1..5 = 5 (shared cell (3,3)):
  - `clear_count`=7.
  - Those cells are 0 in `cleared_board`; all others are unchanged.
- Delayed handshake: `refreshed` held low for 10 cycles after REQ is entered, then high:
  - `ok_to_refresh` stays high throughout, then falls.
  - One `done` pulse follows.
  - A second `start` asserted during REQ is ignored.
- Reset asserted at edge 12 of a match scan:
  - All outputs return to zero at once and no `done` is produced.
  - A fresh `start` then completes normally.
- With `MATCH_SCORE_EN` defined, two consecutive 5-cell clears: `score`=10. With the macro undefined: `score`=0.
